// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory controller slice.
//                Holds the one-hot FSM state encodings, the state enum built
//                on top of them, the performance-counter width and a helper
//                that classifies CPU byte addresses as in/out of SRAM range.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Width of every performance counter.
    localparam int C_CNT_W = 32;

    // One-hot FSM state encodings, explicit 5-bit width.
    localparam int         C_ST_W    = 5;
    localparam logic [4:0] C_ST_IDLE = 5'b00001;
    localparam logic [4:0] C_ST_WR   = 5'b00010;
    localparam logic [4:0] C_ST_RD   = 5'b00100;
    localparam logic [4:0] C_ST_CAP  = 5'b01000;
    localparam logic [4:0] C_ST_RESP = 5'b10000;

    typedef enum logic [C_ST_W-1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_WR   = C_ST_WR,
        ST_RD   = C_ST_RD,
        ST_CAP  = C_ST_CAP,
        ST_RESP = C_ST_RESP
    } state_t;

    // A byte address is out of range when any bit above the SRAM word
    // address field (plus the two byte-offset bits) is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int          addr_w);
        return |(addr >> (addr_w + 2));
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_perf_cnt
//  Description : Three free-running event counters for the data-memory
//                controller: accepted reads, accepted writes and response
//                cycles stalled by the CPU. Each counter wraps from all-ones
//                to zero. Only instantiated when DMEM_PERF_CNT_EN is defined.
//  Ports       : clk      - clock, posedge
//                rst      - synchronous active-low reset (0 = reset)
//                rd_inc   - one accepted read this cycle
//                wr_inc   - one accepted write this cycle
//                wait_inc - one stalled response cycle
//                rd_cnt / wr_cnt / wait_cnt - counter values
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_perf_cnt
    import dmem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_inc,
    input  logic               wr_inc,
    input  logic               wait_inc,
    output logic [C_CNT_W-1:0] rd_cnt,
    output logic [C_CNT_W-1:0] wr_cnt,
    output logic [C_CNT_W-1:0] wait_cnt
);

    logic [C_CNT_W-1:0] r_rd_cnt;
    logic [C_CNT_W-1:0] r_wr_cnt;
    logic [C_CNT_W-1:0] r_wait_cnt;

    // Natural modulo-2^C_CNT_W overflow gives the required wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (rd_inc)   r_rd_cnt   <= r_rd_cnt   + 1'b1;
            if (wr_inc)   r_wr_cnt   <= r_wr_cnt   + 1'b1;
            if (wait_inc) r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign rd_cnt   = r_rd_cnt;
    assign wr_cnt   = r_wr_cnt;
    assign wait_cnt = r_wait_cnt;

endmodule : dmem_perf_cnt
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Single-outstanding-request bridge between a CPU data port
//                and a synchronous single-port SRAM (1-cycle read latency).
//                Writes:  accept T, SRAM write at T+1, ready again at T+2.
//                Reads :  accept T, SRAM read at T+1, capture at T+2,
//                         Read_data_Valid from T+3 until Read_data_Ready.
//                Out-of-range requests never touch the SRAM: writes are
//                dropped and reads return zero.
//  Config      : `define DMEM_PERF_CNT_EN to build the access counters;
//                otherwise the perf_* ports are tied to zero.
//  Ports       : clk, rst (sync, active-low)
//                CPU side : Address, MemWrite, Write_data, Write_strb,
//                           MemRead, Mem_Req_Ready, Read_data,
//                           Read_data_Valid, Read_data_Ready
//                SRAM side: sram_en, sram_we, sram_addr, sram_wdata,
//                           sram_rdata
//                Perf     : perf_rd_cnt, perf_wr_cnt, perf_wait_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    // CPU request
    input  logic [31:0]        Address,
    input  logic               MemWrite,
    input  logic [31:0]        Write_data,
    input  logic [3:0]         Write_strb,
    input  logic               MemRead,
    output logic               Mem_Req_Ready,
    // CPU response
    output logic [31:0]        Read_data,
    output logic               Read_data_Valid,
    input  logic               Read_data_Ready,
    // SRAM
    output logic               sram_en,
    output logic [3:0]         sram_we,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    // Performance counters
    output logic [C_CNT_W-1:0] perf_rd_cnt,
    output logic [C_CNT_W-1:0] perf_wr_cnt,
    output logic [C_CNT_W-1:0] perf_wait_cnt
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;
    logic               r_oor;
    logic [31:0]        r_rdbuf;

    logic               w_accept;
    logic               w_oor;
    logic               w_sram_en;
    logic [3:0]         w_sram_we;
    logic               w_req_ready;
    logic               w_rd_valid;

    // A request is taken whenever the FSM is idle, out of reset, and either
    // request line is high.
    assign w_accept = rst && (r_state == ST_IDLE) && (MemWrite || MemRead);
    assign w_oor    = addr_out_of_range(Address, ADDR_W);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latch: address, data, strobe and range flag are frozen at
    // acceptance so the CPU may change its inputs immediately afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_oor   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= Address[ADDR_W+1:2];
            r_wdata <= Write_data;
            r_strb  <= Write_strb;
            r_oor   <= w_oor;
        end
    end

    // ------------------------------------------------------------------
    // Read buffer: loaded in CAP, the cycle the SRAM presents its data.
    // Held unchanged through RESP so the CPU sees a stable word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdbuf <= '0;
        end else if (r_state == ST_CAP) begin
            r_rdbuf <= r_oor ? 32'h0 : sram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sram_en   = 1'b0;
        w_sram_we   = 4'b0000;
        w_req_ready = 1'b0;
        w_rd_valid  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                // A combined request is treated as a write.
                if (MemWrite) begin
                    w_state_nxt = ST_WR;
                end else if (MemRead) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_WR: begin
                // Out-of-range or empty-strobe writes still spend the WR
                // cycle so write timing never depends on the request.
                if (!r_oor && (r_strb != 4'b0000)) begin
                    w_sram_en = 1'b1;
                    w_sram_we = r_strb;
                end
                w_state_nxt = ST_IDLE;
            end
            ST_RD: begin
                w_sram_en   = 1'b1;
                w_state_nxt = ST_CAP;
            end
            ST_CAP: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rd_valid = 1'b1;
                if (Read_data_Ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Reset masks every handshake/SRAM output immediately, including
        // the cycle in which rst is first sampled low, so an in-flight
        // write can never reach the SRAM once reset is applied.
        if (!rst) begin
            w_sram_en   = 1'b0;
            w_sram_we   = 4'b0000;
            w_req_ready = 1'b0;
            w_rd_valid  = 1'b0;
        end
    end

    assign Mem_Req_Ready   = w_req_ready;
    assign Read_data_Valid = w_rd_valid;
    assign Read_data       = r_rdbuf;
    assign sram_en         = w_sram_en;
    assign sram_we         = w_sram_we;
    assign sram_addr       = r_addr;
    assign sram_wdata      = r_wdata;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef DMEM_PERF_CNT_EN
    logic w_rd_inc;
    logic w_wr_inc;
    logic w_wait_inc;

    assign w_wr_inc   = w_accept && MemWrite;
    assign w_rd_inc   = w_accept && !MemWrite && MemRead;
    assign w_wait_inc = rst && (r_state == ST_RESP) && !Read_data_Ready;

    dmem_perf_cnt u_perf_cnt (
        .clk      (clk),
        .rst      (rst),
        .rd_inc   (w_rd_inc),
        .wr_inc   (w_wr_inc),
        .wait_inc (w_wait_inc),
        .rd_cnt   (perf_rd_cnt),
        .wr_cnt   (perf_wr_cnt),
        .wait_cnt (perf_wait_cnt)
    );
`else
    assign perf_rd_cnt   = '0;
    assign perf_wr_cnt   = '0;
    assign perf_wait_cnt = '0;
`endif

endmodule : data_mem_ctrl
`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, SRAM word-address width (64 KiB).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 SHALL have port Address  input  32  byte address from CPU; bits [1:0] ignored.
REQ-005 SHALL have port MemWrite  input  1  write request valid.
REQ-006 SHALL have port Write_data  input  32  pre-aligned write data.
REQ-007 SHALL have port Write_strb  input  4  byte enables.
REQ-008 SHALL have port MemRead  input  1  read request valid.
REQ-009 SHALL have port Mem_Req_Ready  output  1  request accepted this cycle when high with MemRead or MemWrite.
REQ-010 SHALL have port Read_data  output  32  full read word.
REQ-011 SHALL have port Read_data_Valid  output  1  Read_data valid.
REQ-012 SHALL have port Read_data_Ready  input  1  CPU consumes Read_data.
REQ-013 SHALL have port sram_en  output  1  SRAM access enable.
REQ-014 SHALL have port sram_we  output  4  SRAM byte write enables.
REQ-015 SHALL have port sram_addr  output  ADDR_W  SRAM word address.
REQ-016 SHALL have port sram_wdata  output  32  SRAM write data.
REQ-017 SHALL have port sram_rdata  input  32  SRAM read data, valid the cycle after sram_en with sram_we==0.
REQ-018 SHALL have ports perf_rd_cnt, perf_wr_cnt, perf_wait_cnt  output  32 each  access counters.

Function
REQ-019 SHALL implement FSM states IDLE, WR, RD, CAP, RESP.
REQ-020 SHALL assert Mem_Req_Ready only in IDLE.
REQ-021 SHALL, in IDLE, latch Address[ADDR_W+1:2], Write_data, Write_strb and an out-of-range flag (Address[31:ADDR_W+2] != 0) when MemWrite or MemRead is high.
REQ-022 SHALL, in IDLE with MemWrite high, go to WR; MemWrite wins if MemRead is also high.
REQ-023 SHALL, in IDLE with MemRead high and MemWrite low, go to RD.
REQ-024 SHALL, in WR, drive sram_en=1 and sram_we=latched strb, then return to IDLE: accept cycle T, write at T+1, ready again at T+2.
REQ-025 SHALL, in WR, drive sram_en=0 and sram_we=0 if the request was out of range or the strobe was zero, while keeping the same timing.
REQ-026 SHALL, in RD, drive sram_en=1 and sram_we=0, then go to CAP.
REQ-027 SHALL, in CAP, register sram_rdata (or 0 if out of range) into the read buffer, then go to RESP.
REQ-028 SHALL, in RESP, hold Read_data_Valid=1 and Read_data=buffer stable until Read_data_Ready=1, then return to IDLE: accept T, valid from T+3.
REQ-029 SHALL drive sram_en=0 and sram_we=0 in all states other than WR and RD.
REQ-030 SHALL keep Read_data_Valid low outside RESP and accept no new request in RESP.

Reset
REQ-031 SHALL, while rst=0, force FSM=IDLE, the read buffer to 0, sram_en=0, sram_we=0, Read_data_Valid=0 and all counters to 0.
REQ-032 SHALL, on reset mid-operation, abandon any pending write or read with no SRAM write after the reset cycle.
REQ-033 SHALL drive Mem_Req_Ready=0 during reset and 1 in the first cycle after rst rises.

Configuration
REQ-034 SHALL, with DMEM_PERF_CNT_EN defined, count accepted reads (perf_rd_cnt), accepted writes (perf_wr_cnt) and RESP cycles with Read_data_Ready low (perf_wait_cnt), each 32-bit and wrapping 0xFFFFFFFF->0.
REQ-035 SHALL, without DMEM_PERF_CNT_EN, keep the perf ports present and tied to 0 with no counter flops.

Structure
REQ-036 SHALL take the FSM one-hot state localparams and the counter width from shared package dmem_pkg.
REQ-037 SHALL place the counters in one sub-module dmem_perf_cnt, instantiated only under DMEM_PERF_CNT_EN.

Verification
REQ-038 SHALL cover: write 0x12345678 strb 0xF to 0x100, then read 0x100 -> sram_we=0xF with sram_addr=0x40 at T+1, Read_data=0x12345678 at T+3.
REQ-039 SHALL cover: strb 0x2 write of 0x0000AB00 over 0xFFFFFFFF, then read -> 0xFFFFABFF.
REQ-040 SHALL cover: read with Read_data_Ready held low 5 cycles -> Valid and data stable, Mem_Req_Ready=0 throughout, perf_wait_cnt=5 (macro on).
REQ-041 SHALL cover: write to 0x00100000 (out of range) -> sram_we=0, ready at T+2; read of the same address -> Read_data=0.
REQ-042 SHALL cover: MemRead and MemWrite both high -> write performed, perf_wr_cnt+1 and perf_rd_cnt unchanged.
REQ-043 SHALL cover: rst=0 asserted in WR -> no sram_we after reset, FSM in IDLE, counters 0.
